// File: rtl/id_hazard_ctrl_if.sv
// Decode-side hazard control bundle: decoded operands, writeback
// retire port and the resulting pipeline sequencing controls.
interface id_hazard_ctrl_if #(
    parameter int NREG = 8,
    parameter int RW   = 3
);
    logic            dec_valid;
    logic [RW-1:0]   src1;
    logic [RW-1:0]   src2;
    logic [RW-1:0]   src3;
    logic [2:0]      use_src;
    logic [RW-1:0]   dst;
    logic            dst_we;
    logic            jump;
    logic            wb_valid;
    logic [RW-1:0]   wb_reg;
    logic            issue;
    logic            pc_en;
    logic            bubble;
    logic            squash;
    logic [NREG-1:0] busy;
    logic            err;

    modport master (
        output dec_valid, src1, src2, src3, use_src,
        output dst, dst_we, jump, wb_valid, wb_reg,
        input  issue, pc_en, bubble, squash, busy, err
    );

    modport slave (
        input  dec_valid, src1, src2, src3, use_src,
        input  dst, dst_we, jump, wb_valid, wb_reg,
        output issue, pc_en, bubble, squash, busy, err
    );
endinterface

// File: rtl/id_hazard_ctrl.sv
// Decode-stage scoreboard: per-register pending-write counters,
// RAW/WAW stall generation and post-jump squash sequencing.
module id_hazard_ctrl #(
    parameter int ARQ       = 16,
    parameter int NREG      = 8,
    parameter int FLUSH_CYC = 1
) (
    input logic            clk,
    input logic            rst,
    id_hazard_ctrl_if.slave bus
);
    localparam int RW = $clog2(NREG);

    typedef enum logic {
        RUN   = 1'b0,
        FLUSH = 1'b1
    } state_t;

    if (FLUSH_CYC < 1 || FLUSH_CYC > 7 || ARQ < 1) begin : g_bad_param
        $error("id_hazard_ctrl: illegal parameter value");
    end

    state_t     state;
    logic [2:0] fcnt;
    logic       err_q;
    logic [1:0] cnt     [NREG];
    logic [1:0] cnt_nxt [NREG];
    logic [RW-1:0] srcs [3];

    logic raw;
    logic waw;
    logic hazard;
    logic issue;
    logic pc_en;
    logic bubble;
    logic squash;
    logic wb_spur;

    assign srcs[0] = bus.src1;
    assign srcs[1] = bus.src2;
    assign srcs[2] = bus.src3;

    // Hazards look only at registered counts; no writeback bypass.
    always_comb begin
        raw = 1'b0;
        for (int i = 0; i < 3; i++) begin
            if (bus.use_src[i] && cnt[srcs[i]] != 2'd0) raw = 1'b1;
        end
    end

    assign waw    = bus.dst_we && cnt[bus.dst] == 2'd3;
    assign hazard = bus.dec_valid && (raw || waw);

    always_comb begin
        issue  = 1'b0;
        pc_en  = 1'b0;
        bubble = 1'b1;
        squash = 1'b0;
        if (rst) begin
            if (state == FLUSH) begin
                pc_en  = 1'b1;
                squash = 1'b1;
            end else if (hazard) begin
                pc_en  = 1'b0;
            end else if (bus.dec_valid) begin
                issue  = 1'b1;
                pc_en  = 1'b1;
                bubble = 1'b0;
            end else begin
                pc_en  = 1'b1;
            end
        end
    end

    always_comb begin
        for (int r = 0; r < NREG; r++) begin
            logic inc;
            logic dec;
            inc = issue && bus.dst_we && bus.dst == RW'(r);
            dec = bus.wb_valid && bus.wb_reg == RW'(r)
                  && cnt[r] != 2'd0;
            cnt_nxt[r] = cnt[r];
            if (inc && !dec) cnt_nxt[r] = cnt[r] + 2'd1;
            else if (dec && !inc) cnt_nxt[r] = cnt[r] - 2'd1;
        end
    end

    assign wb_spur = bus.wb_valid && cnt[bus.wb_reg] == 2'd0;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= RUN;
            fcnt  <= 3'd0;
            err_q <= 1'b0;
            for (int r = 0; r < NREG; r++) cnt[r] <= 2'd0;
        end else begin
            for (int r = 0; r < NREG; r++) cnt[r] <= cnt_nxt[r];
            if (wb_spur) err_q <= 1'b1;
            case (state)
                RUN: begin
                    if (issue && bus.jump) begin
                        state <= FLUSH;
                        fcnt  <= 3'(FLUSH_CYC);
                    end
                end
                FLUSH: begin
                    fcnt <= fcnt - 3'd1;
                    if (fcnt == 3'd1) state <= RUN;
                end
                default: state <= RUN;
            endcase
        end
    end

    always_comb begin
        bus.busy = '0;
        for (int r = 0; r < NREG; r++) begin
            bus.busy[r] = rst && cnt[r] != 2'd0;
        end
    end

    assign bus.issue  = issue;
    assign bus.pc_en  = pc_en;
    assign bus.bubble = bubble;
    assign bus.squash = squash;
    assign bus.err    = err_q;
endmodule

// File: tb/tb_id_hazard_ctrl.sv
// Directed bench for id_hazard_ctrl: reset, RAW/WAW stalls,
// simultaneous inc/dec, jump squash, spurious writeback.
module tb_id_hazard_ctrl;
    logic clk;
    logic rst;
    int   checks;
    int   failures;

    id_hazard_ctrl_if #(.NREG(8), .RW(3)) bus ();

    id_hazard_ctrl #(
        .ARQ(16), .NREG(8), .FLUSH_CYC(2)
    ) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    wire [3:0] ctl = {bus.issue, bus.pc_en, bus.bubble, bus.squash};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.dec_valid = 1'b0;
        bus.src1 = 3'd0;
        bus.src2 = 3'd0;
        bus.src3 = 3'd0;
        bus.use_src = 3'b000;
        bus.dst = 3'd0;
        bus.dst_we = 1'b0;
        bus.jump = 1'b0;
        bus.wb_valid = 1'b0;
        bus.wb_reg = 3'd0;
    endtask

    task automatic writer(input logic [2:0] d);
        idle();
        bus.dec_valid = 1'b1;
        bus.dst = d;
        bus.dst_we = 1'b1;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            bus.dec_valid = 1'($urandom);
            bus.src1 = 3'($urandom);
            bus.src2 = 3'($urandom);
            bus.src3 = 3'($urandom);
            bus.use_src = 3'($urandom);
            bus.dst = 3'($urandom);
            bus.dst_we = 1'($urandom);
            bus.jump = 1'($urandom);
            bus.wb_valid = 1'($urandom);
            bus.wb_reg = 3'($urandom);
            #1;
            checks++;
            if (ctl !== 4'b0010) begin
                failures++;
                $display("FAIL reset_ctl: got %b expected 0010", ctl);
            end
            checks++;
            if (bus.busy !== 8'h00 || bus.err !== 1'b0) begin
                failures++;
                $display("FAIL reset_busy: got busy=%h err=%b expected 00/0",
                         bus.busy, bus.err);
            end
            cyc();
        end
        idle();
        bus.dec_valid = 1'b1;
        rst = 1'b1;
        #1;
        checks++;
        if (ctl !== 4'b1100) begin
            failures++;
            $display("FAIL reset_release_issue: got %b expected 1100", ctl);
        end
        cyc();
        idle();
    endtask

    task automatic test_raw_stall();
        writer(3'd3);
        #1;
        checks++;
        if (ctl !== 4'b1100) begin
            failures++;
            $display("FAIL raw_writer: got %b expected 1100", ctl);
        end
        cyc();
        idle();
        bus.dec_valid = 1'b1;
        bus.src1 = 3'd3;
        bus.use_src = 3'b001;
        for (int c = 1; c <= 4; c++) begin
            if (c == 4) begin
                bus.wb_valid = 1'b1;
                bus.wb_reg = 3'd3;
            end
            #1;
            checks++;
            if (ctl !== 4'b0010 || bus.busy !== 8'h08) begin
                failures++;
                $display("FAIL raw_stall_c%0d: got ctl=%b busy=%h expected 0010/08",
                         c, ctl, bus.busy);
            end
            cyc();
        end
        bus.wb_valid = 1'b0;
        #1;
        checks++;
        if (ctl !== 4'b1100 || bus.busy !== 8'h00) begin
            failures++;
            $display("FAIL raw_release: got ctl=%b busy=%h expected 1100/00",
                     ctl, bus.busy);
        end
        cyc();
        idle();
    endtask

    task automatic test_saturation();
        writer(3'd5);
        for (int n = 0; n < 3; n++) begin
            #1;
            checks++;
            if (bus.issue !== 1'b1) begin
                failures++;
                $display("FAIL sat_writer%0d: got issue=%b expected 1",
                         n, bus.issue);
            end
            cyc();
        end
        #1;
        checks++;
        if (ctl !== 4'b0010 || bus.busy !== 8'h20) begin
            failures++;
            $display("FAIL sat_stall: got ctl=%b busy=%h expected 0010/20",
                     ctl, bus.busy);
        end
        cyc();
        bus.wb_valid = 1'b1;
        bus.wb_reg = 3'd5;
        #1;
        checks++;
        if (bus.issue !== 1'b0) begin
            failures++;
            $display("FAIL sat_no_bypass: got issue=%b expected 0", bus.issue);
        end
        cyc();
        bus.wb_valid = 1'b0;
        #1;
        checks++;
        if (bus.issue !== 1'b1) begin
            failures++;
            $display("FAIL sat_release: got issue=%b expected 1", bus.issue);
        end
        cyc();
        idle();
        bus.wb_valid = 1'b1;
        bus.wb_reg = 3'd5;
        for (int n = 0; n < 3; n++) cyc();
        idle();
        #1;
        checks++;
        if (bus.busy !== 8'h00 || bus.err !== 1'b0) begin
            failures++;
            $display("FAIL sat_drain: got busy=%h err=%b expected 00/0",
                     bus.busy, bus.err);
        end
    endtask

    task automatic test_inc_dec();
        writer(3'd2);
        cyc();
        writer(3'd2);
        bus.wb_valid = 1'b1;
        bus.wb_reg = 3'd2;
        #1;
        checks++;
        if (bus.issue !== 1'b1) begin
            failures++;
            $display("FAIL incdec_issue: got issue=%b expected 1", bus.issue);
        end
        cyc();
        idle();
        #1;
        checks++;
        if (bus.busy !== 8'h04) begin
            failures++;
            $display("FAIL incdec_busy: got %h expected 04", bus.busy);
        end
        bus.wb_valid = 1'b1;
        bus.wb_reg = 3'd2;
        cyc();
        idle();
        #1;
        checks++;
        if (bus.busy !== 8'h00 || bus.err !== 1'b0) begin
            failures++;
            $display("FAIL incdec_drain: got busy=%h err=%b expected 00/0",
                     bus.busy, bus.err);
        end
    endtask

    task automatic test_self_dep();
        writer(3'd7);
        bus.src1 = 3'd7;
        bus.use_src = 3'b001;
        #1;
        checks++;
        if (bus.issue !== 1'b1) begin
            failures++;
            $display("FAIL selfdep_first: got issue=%b expected 1", bus.issue);
        end
        cyc();
        #1;
        checks++;
        if (bus.issue !== 1'b0 || bus.busy !== 8'h80) begin
            failures++;
            $display("FAIL selfdep_second: got issue=%b busy=%h expected 0/80",
                     bus.issue, bus.busy);
        end
        idle();
        bus.wb_valid = 1'b1;
        bus.wb_reg = 3'd7;
        cyc();
        idle();
    endtask

    task automatic test_jump_flush();
        idle();
        bus.dec_valid = 1'b1;
        bus.jump = 1'b1;
        #1;
        checks++;
        if (ctl !== 4'b1100) begin
            failures++;
            $display("FAIL jump_issue: got %b expected 1100", ctl);
        end
        cyc();
        writer(3'd4);
        for (int c = 1; c <= 2; c++) begin
            #1;
            checks++;
            if (ctl !== 4'b0111 || bus.busy !== 8'h00) begin
                failures++;
                $display("FAIL jump_flush_c%0d: got ctl=%b busy=%h expected 0111/00",
                         c, ctl, bus.busy);
            end
            cyc();
        end
        idle();
        bus.dec_valid = 1'b1;
        #1;
        checks++;
        if (ctl !== 4'b1100 || bus.busy !== 8'h00) begin
            failures++;
            $display("FAIL jump_resume: got ctl=%b busy=%h expected 1100/00",
                     ctl, bus.busy);
        end
        cyc();
        idle();
    endtask

    task automatic test_jump_stalled_reset();
        writer(3'd1);
        cyc();
        idle();
        bus.dec_valid = 1'b1;
        bus.jump = 1'b1;
        bus.src2 = 3'd1;
        bus.use_src = 3'b010;
        #1;
        checks++;
        if (ctl !== 4'b0010) begin
            failures++;
            $display("FAIL jstall_hold: got %b expected 0010", ctl);
        end
        cyc();
        #1;
        checks++;
        if (ctl !== 4'b0010) begin
            failures++;
            $display("FAIL jstall_no_flush: got %b expected 0010", ctl);
        end
        bus.wb_valid = 1'b1;
        bus.wb_reg = 3'd1;
        cyc();
        bus.wb_valid = 1'b0;
        #1;
        checks++;
        if (ctl !== 4'b1100) begin
            failures++;
            $display("FAIL jstall_issue: got %b expected 1100", ctl);
        end
        cyc();
        writer(3'd6);
        #1;
        checks++;
        if (ctl !== 4'b0111) begin
            failures++;
            $display("FAIL jstall_flush: got %b expected 0111", ctl);
        end
        rst = 1'b0;
        #1;
        checks++;
        if (ctl !== 4'b0010 || bus.busy !== 8'h00) begin
            failures++;
            $display("FAIL abort_reset: got ctl=%b busy=%h expected 0010/00",
                     ctl, bus.busy);
        end
        cyc();
        idle();
        bus.dec_valid = 1'b1;
        rst = 1'b1;
        #1;
        checks++;
        if (ctl !== 4'b1100) begin
            failures++;
            $display("FAIL abort_run: got %b expected 1100", ctl);
        end
        cyc();
        idle();
    endtask

    task automatic test_spurious_wb();
        idle();
        bus.wb_valid = 1'b1;
        bus.wb_reg = 3'd6;
        #1;
        checks++;
        if (bus.err !== 1'b0) begin
            failures++;
            $display("FAIL spur_same_cycle: got err=%b expected 0", bus.err);
        end
        cyc();
        idle();
        for (int c = 0; c < 2; c++) begin
            #1;
            checks++;
            if (bus.err !== 1'b1 || bus.busy !== 8'h00) begin
                failures++;
                $display("FAIL spur_sticky%0d: got err=%b busy=%h expected 1/00",
                         c, bus.err, bus.busy);
            end
            cyc();
        end
        rst = 1'b0;
        #1;
        checks++;
        if (bus.err !== 1'b0) begin
            failures++;
            $display("FAIL spur_clear: got err=%b expected 0", bus.err);
        end
        cyc();
        rst = 1'b1;
        #1;
        checks++;
        if (bus.err !== 1'b0) begin
            failures++;
            $display("FAIL spur_after_rst: got err=%b expected 0", bus.err);
        end
    endtask

    initial begin
        checks = 0;
        failures = 0;
        rst = 1'b0;
        idle();
        cyc();
        test_reset();
        test_raw_stall();
        test_saturation();
        test_inc_dec();
        test_self_dep();
        test_jump_flush();
        test_jump_stalled_reset();
        test_spurious_wb();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
